// File: rtl/photons_dbg_pkg.sv
// Shared debug definitions for the photons_maxi_id stall/deadlock monitors.
package photons_dbg_pkg;

   // Default stall threshold, kept in step with the hls_deadlock monitor configuration.
   localparam int unsigned DBG_THRESH_DEFAULT = 1024;

   typedef enum logic {
      IDLE   = 1'b0,
      REPORT = 1'b1
   } rpt_state_e;

   function automatic int unsigned chan_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/photons_axis_stall_counter.sv
// Per-channel saturating stall counter with registered threshold flag.
module photons_axis_stall_counter
   import photons_dbg_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned THRESH = DBG_THRESH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             tvalid_i,
   input  logic             tready_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             block_o,
   output logic             block_d_o
);

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             block_q, block_d;
   logic             stall;

   always_comb begin
      stall = tvalid_i ^ tready_i;
      cnt_d = '0;
      if (!clear_i && stall) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;
      end
      block_d = (cnt_d >= THRESH_C);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         block_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         block_q <= block_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign block_o   = block_q;
   assign block_d_o = block_d;

endmodule

// File: rtl/photons_axis_block_detector.sv
// AXI-Stream stall detector: per-channel block flags plus a first-stall report handshake.
module photons_axis_block_detector
   import photons_dbg_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned THRESH = DBG_THRESH_DEFAULT
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_CH-1:0]           ch_tvalid,
   input  logic [NUM_CH-1:0]           ch_tready,
   output logic [NUM_CH-1:0]           axis_block_sigs,
   output logic                        any_block,
   output logic                        report_valid,
   output logic [chan_w(NUM_CH)-1:0]   report_chan,
   output logic [CNT_W-1:0]            report_cycles,
   input  logic                        report_ack
);

   localparam int unsigned CH_W = chan_w(NUM_CH);

   logic [CNT_W-1:0]  ch_cnt [NUM_CH];
   logic [NUM_CH-1:0] blk_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      photons_axis_stall_counter #(
         .CNT_W  (CNT_W),
         .THRESH (THRESH)
      ) u_cnt (
         .clock     (clock),
         .reset     (reset),
         .clear_i   (~enable),
         .tvalid_i  (ch_tvalid[i]),
         .tready_i  (ch_tready[i]),
         .cnt_o     (ch_cnt[i]),
         .block_o   (axis_block_sigs[i]),
         .block_d_o (blk_d[i])
      );
   end

   rpt_state_e        state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d, cand, pick_oh;
   logic [CH_W-1:0]   pick_idx, chan_q, chan_d;
   logic [CNT_W-1:0]  pick_cnt, cycles_q, cycles_d;
   logic              valid_q, valid_d, any_q, latch;

   // Descending scan so the lowest-index candidate is the last one written.
   always_comb begin
      cand     = axis_block_sigs & ~mask_q;
      pick_idx = '0;
      pick_cnt = '0;
      pick_oh  = '0;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (cand[i-1]) begin
            pick_idx     = CH_W'(i - 1);
            pick_cnt     = ch_cnt[i-1];
            pick_oh      = '0;
            pick_oh[i-1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|cand) state_d = REPORT;
         REPORT:  if (report_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      latch    = (state_q == IDLE) && (|cand);
      mask_d   = (mask_q & axis_block_sigs) | (latch ? pick_oh : '0);
      chan_d   = latch ? pick_idx : chan_q;
      cycles_d = latch ? pick_cnt : cycles_q;
      valid_d  = (state_d == REPORT);
   end

   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         mask_q   <= '0;
         any_q    <= 1'b0;
         valid_q  <= 1'b0;
         chan_q   <= '0;
         cycles_q <= '0;
      end else begin
         mask_q   <= mask_d;
         any_q    <= |blk_d;
         valid_q  <= valid_d;
         chan_q   <= chan_d;
         cycles_q <= cycles_d;
      end
   end

   assign any_block     = any_q;
   assign report_valid  = valid_q;
   assign report_chan   = chan_q;
   assign report_cycles = cycles_q;

endmodule

// File: doc/photons_axis_block_detector.md
Name: photons_axis_block_detector

Overview:
Per-channel AXI-Stream stall detector for the photons_maxi_id HLS datapath. It produces the axis_block_sigs vector that feeds the hls_deadlock monitor. It also raises a handshaked report identifying which channel stalled first and for how long. It passively taps tvalid/tready of each observed stream, one instance per HLS dataflow region.

Parameters:
NUM_CH, 4, number of observed AXIS channels (1..16)
CNT_W, 16, stall counter width
THRESH, 1024, consecutive stall cycles before a channel is declared blocked (1..2^CNT_W-1)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  detector enable; 0 holds everything cleared
ch_tvalid  in  NUM_CH  tapped tvalid per channel
ch_tready  in  NUM_CH  tapped tready per channel
axis_block_sigs  out  NUM_CH  per-channel blocked flag, to deadlock monitor
any_block  out  1  OR of axis_block_sigs, registered
report_valid  out  1  report pending
report_chan  out  max(1,clog2(NUM_CH))  index of reported channel
report_cycles  out  CNT_W  stall count of that channel at latch time
report_ack  in  1  consumer accepts report

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All state updates on posedge clock.
- Reset values: all counters 0, axis_block_sigs 0, any_block 0, report_valid 0, report_chan 0, report_cycles 0, reported mask 0, FSM IDLE.
- Per-channel stall = tvalid XOR tready: a full/backpressured producer or a starved consumer. Transfer (both 1) and idle (both 0) are not stalls.
- Counter: on a stall cycle, cnt <= cnt+1, saturating at all-ones with no wrap. On a non-stall cycle, cnt <= 0.
- axis_block_sigs[i] is registered, computed from the next counter value (cnt_next >= THRESH). It rises on the edge that ends the THRESH-th consecutive stall cycle. It falls on the edge after the first non-stall cycle.
- any_block is registered from the next value of axis_block_sigs, so it rises on the same edge as the block flag.
- Reported mask: bit i is set when channel i is latched into a report. It clears when axis_block_sigs[i] is 0. A channel reports once per blocking episode.
- Candidates = axis_block_sigs & ~mask.
- FSM IDLE:
  - If candidates != 0, latch the lowest-index candidate into report_chan.
  - Latch its current counter into report_cycles and set the mask bit.
  - Go to REPORT with report_valid=1. Latency is one cycle after the block flag rises.
- FSM REPORT:
  - report_valid held high; report_chan and report_cycles held stable.
  - On report_ack=1, report_valid drops next edge and the FSM returns to IDLE. A new report may start no earlier than the following cycle.
- A channel unblocking while its report is pending does not retract the report.
- Simultaneous blocking on several channels: the lowest index reports first. The others remain candidates and report in successive IDLE passes.
- report_ack in IDLE is ignored.
- enable=0, same cycle effect at next edge: counters, flags, mask, and report outputs clear; FSM goes to IDLE. This is identical to reset except the reset port itself.
- Reset mid-report: report_valid drops next edge, with no handshake completion.
- THRESH=1: a single stall cycle blocks.

Decomposition:
- Shared package photons_dbg_pkg:
  - FSM state enum (IDLE, REPORT)
  - function for the chan index width
  - default THRESH constant shared with the deadlock monitor configuration
- One natural sub-module: photons_axis_stall_counter, one per channel, generated NUM_CH times. It holds the saturating counter, the threshold compare, and the registered block flag.
- The top holds the mask, the priority encoder and the report FSM.

Test Plan:
- THRESH=8. Ch0 tvalid=1, tready=0 for 8 cycles -> axis_block_sigs=0001 on the 8th edge, report_valid next cycle, report_chan=0, report_cycles=8. Ack -> report_valid=0; no re-report while still stalled.
- Ch2 stalls 7 cycles, then one transfer, then 7 more stalls -> axis_block_sigs stays 0 and no report, proving the counter clears.
- Ch1 and ch3 stall from the same cycle for 10 cycles; ack each report one cycle after valid -> first report chan=1 with cycles=8, second report chan=3 with cycles ≥9; both flags high.
- CNT_W=4, THRESH=8, 40 stall cycles -> counter saturates at 15 and never wraps; flag stays 1; after release the flag drops one edge later.
- Report pending on ch0 with no ack, ch0 unblocks -> report held unchanged. After ack, ch0 blocks again after 8 stalls -> new report issued because the mask was cleared.
- Blocked channel with pending report, then enable=0 (or reset=1) for one cycle -> all outputs 0 next edge; re-enable -> 8 fresh stall cycles are required to re-block.
